// File: rtl/health_shield_ctrl_pkg.sv
// Shared fighter constants for the health/shield controller: default vitals and frame timings,
// round state and winner encodings, and saturating 5-bit helpers.
package health_shield_ctrl_pkg;

    localparam int FC_MAX_HEALTH    = 14;
    localparam int FC_MAX_SHIELD    = 14;
    localparam int FC_INVULN_FRAMES = 30;
    localparam int FC_REGEN_FRAMES  = 60;
    localparam int CNT_W            = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FIGHT = 2'b01,
        ST_KO    = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    function automatic logic [4:0] sat_sub5(input logic [4:0] a, input logic [4:0] b);
        if (a > b) begin
            return a - b;
        end else begin
            return 5'd0;
        end
    endfunction

    function automatic logic [4:0] sat_inc5(input logic [4:0] a, input logic [4:0] lim);
        if (a < lim) begin
            return a + 5'd1;
        end else begin
            return lim;
        end
    endfunction

endpackage

// File: rtl/health_shield_ctrl_if.sv
// Game-side bundle of the health/shield controller: frame/round pulses, hits and bar outputs.
interface health_shield_ctrl_if;

    logic       frame_tick;
    logic       start;
    logic       p1_hit;
    logic       p2_hit;
    logic [1:0] p1_dmg;
    logic [1:0] p2_dmg;
    logic       p1_blocking;
    logic       p2_blocking;
    logic [3:0] p1_health;
    logic [3:0] p2_health;
    logic [3:0] p1_shield;
    logic [3:0] p2_shield;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output frame_tick, start, p1_hit, p2_hit, p1_dmg, p2_dmg, p1_blocking, p2_blocking,
        input  p1_health, p2_health, p1_shield, p2_shield, game_over, winner
    );

    modport slave (
        input  frame_tick, start, p1_hit, p2_hit, p1_dmg, p2_dmg, p1_blocking, p2_blocking,
        output p1_health, p2_health, p1_shield, p2_shield, game_over, winner
    );

endinterface

// File: rtl/health_shield_ctrl_player_vitals.sv
// One player's health, shield, hit-immunity and shield-regeneration state.
// load reloads the maxima; active gates hits and frame-driven counters (vitals freeze otherwise).
module player_vitals
    import health_shield_ctrl_pkg::*;
#(
    parameter int MAX_HEALTH    = FC_MAX_HEALTH,
    parameter int MAX_SHIELD    = FC_MAX_SHIELD,
    parameter int INVULN_FRAMES = FC_INVULN_FRAMES,
    parameter int REGEN_FRAMES  = FC_REGEN_FRAMES
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       active,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic [1:0] dmg,
    input  logic       blocking,
    output logic [3:0] health,
    output logic [3:0] shield
);

    localparam logic [4:0]       HEALTH_MAX_L = 5'(MAX_HEALTH);
    localparam logic [4:0]       SHIELD_MAX_L = 5'(MAX_SHIELD);
    localparam logic [CNT_W-1:0] INVULN_L     = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0] REGEN_LAST_L = CNT_W'(REGEN_FRAMES - 1);

    logic [3:0]       health_r, shield_r, health_nx_s, shield_nx_s;
    logic [CNT_W-1:0] invuln_r, regen_r, invuln_nx_s, regen_nx_s;
    logic [4:0]       h5_s, s5_s, d5_s;
    logic             hit_ok_s;

    // Next-state of the vitals: reload, freeze, accepted hit, or frame-tick housekeeping.
    always_comb begin
        health_nx_s = health_r;
        shield_nx_s = shield_r;
        invuln_nx_s = invuln_r;
        regen_nx_s  = regen_r;
        h5_s        = {1'b0, health_r};
        s5_s        = {1'b0, shield_r};
        d5_s        = {3'b000, dmg};
        hit_ok_s    = active && hit && (dmg != 2'd0) && (invuln_r == CNT_W'(0));
        if (load) begin
            health_nx_s = 4'(HEALTH_MAX_L);
            shield_nx_s = 4'(SHIELD_MAX_L);
            invuln_nx_s = CNT_W'(0);
            regen_nx_s  = CNT_W'(0);
        end else if (!active) begin
            health_nx_s = health_r;
        end else if (hit_ok_s) begin
            // A landed hit wins over a coincident frame tick: no regen, immunity reloaded.
            invuln_nx_s = INVULN_L;
            regen_nx_s  = CNT_W'(0);
            if (!blocking) begin
                health_nx_s = 4'(sat_sub5(h5_s, d5_s));
            end else if (s5_s >= d5_s) begin
                shield_nx_s = 4'(s5_s - d5_s);
            end else begin
                shield_nx_s = 4'd0;
                health_nx_s = 4'(sat_sub5(h5_s, d5_s - s5_s));
            end
        end else if (frame_tick) begin
            invuln_nx_s = (invuln_r == CNT_W'(0)) ? CNT_W'(0) : invuln_r - CNT_W'(1);
            if (blocking) begin
                regen_nx_s = CNT_W'(0);
            end else if (regen_r == REGEN_LAST_L) begin
                regen_nx_s  = CNT_W'(0);
                shield_nx_s = 4'(sat_inc5(s5_s, SHIELD_MAX_L));
            end else begin
                regen_nx_s = regen_r + CNT_W'(1);
            end
        end else if (blocking) begin
            regen_nx_s = CNT_W'(0);
        end else begin
            regen_nx_s = regen_r;
        end
    end

    // Vitals registers with synchronous reset to full health and shield.
    always_ff @(posedge clk) begin
        if (reset) begin
            health_r <= 4'(HEALTH_MAX_L);
            shield_r <= 4'(SHIELD_MAX_L);
            invuln_r <= CNT_W'(0);
            regen_r  <= CNT_W'(0);
        end else begin
            health_r <= health_nx_s;
            shield_r <= shield_nx_s;
            invuln_r <= invuln_nx_s;
            regen_r  <= regen_nx_s;
        end
    end

    assign health = health_r;
    assign shield = shield_r;

endmodule

// File: rtl/health_shield_ctrl.sv
// Two-player health/shield controller: round FSM (IDLE/FIGHT/KO), winner decision,
// and one player_vitals instance per player.
module health_shield_ctrl
    import health_shield_ctrl_pkg::*;
#(
    parameter int MAX_HEALTH    = FC_MAX_HEALTH,
    parameter int MAX_SHIELD    = FC_MAX_SHIELD,
    parameter int INVULN_FRAMES = FC_INVULN_FRAMES,
    parameter int REGEN_FRAMES  = FC_REGEN_FRAMES
)(
    input  logic                 clk,
    input  logic                 reset,
    health_shield_ctrl_if.slave  bus
);

    state_e     state_r;
    winner_e    winner_r;
    logic       game_over_r;
    logic [3:0] p1_health_s, p2_health_s, p1_shield_s, p2_shield_s;
    logic       p1_dead_s, p2_dead_s, active_s, load_s;

    // Vitals only move while both players still stand; a KO freezes them until restart.
    always_comb begin
        p1_dead_s = (p1_health_s == 4'd0);
        p2_dead_s = (p2_health_s == 4'd0);
        active_s  = (state_r == ST_FIGHT) && !p1_dead_s && !p2_dead_s;
        load_s    = (state_r == ST_IDLE) || ((state_r == ST_KO) && bus.start);
    end

    player_vitals #(
        .MAX_HEALTH(MAX_HEALTH), .MAX_SHIELD(MAX_SHIELD),
        .INVULN_FRAMES(INVULN_FRAMES), .REGEN_FRAMES(REGEN_FRAMES)
    ) u_p1 (
        .clk(clk), .reset(reset), .load(load_s), .active(active_s),
        .frame_tick(bus.frame_tick), .hit(bus.p1_hit), .dmg(bus.p1_dmg),
        .blocking(bus.p1_blocking), .health(p1_health_s), .shield(p1_shield_s)
    );

    player_vitals #(
        .MAX_HEALTH(MAX_HEALTH), .MAX_SHIELD(MAX_SHIELD),
        .INVULN_FRAMES(INVULN_FRAMES), .REGEN_FRAMES(REGEN_FRAMES)
    ) u_p2 (
        .clk(clk), .reset(reset), .load(load_s), .active(active_s),
        .frame_tick(bus.frame_tick), .hit(bus.p2_hit), .dmg(bus.p2_dmg),
        .blocking(bus.p2_blocking), .health(p2_health_s), .shield(p2_shield_s)
    );

    // Round FSM with registered game_over and winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            game_over_r <= 1'b0;
            winner_r    <= WIN_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r <= ST_FIGHT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FIGHT: begin
                    if (p1_dead_s || p2_dead_s) begin
                        state_r     <= ST_KO;
                        game_over_r <= 1'b1;
                        if (p1_dead_s && p2_dead_s) begin
                            winner_r <= WIN_DRAW;
                        end else if (p1_dead_s) begin
                            winner_r <= WIN_P2;
                        end else begin
                            winner_r <= WIN_P1;
                        end
                    end else begin
                        state_r <= ST_FIGHT;
                    end
                end
                ST_KO: begin
                    if (bus.start) begin
                        state_r     <= ST_FIGHT;
                        game_over_r <= 1'b0;
                        winner_r    <= WIN_NONE;
                    end else begin
                        state_r <= ST_KO;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    game_over_r <= 1'b0;
                    winner_r    <= WIN_NONE;
                end
            endcase
        end
    end

    assign bus.p1_health = p1_health_s;
    assign bus.p2_health = p2_health_s;
    assign bus.p1_shield = p1_shield_s;
    assign bus.p2_shield = p2_shield_s;
    assign bus.game_over = game_over_r;
    assign bus.winner    = winner_r;

endmodule

// File: tb/tb_health_shield_ctrl.sv
// Bench for health_shield_ctrl: directed round scenarios plus randomized play, every cycle
// compared against an integer reference model of the round and damage rules.
module tb_health_shield_ctrl;

    localparam int MH  = 14;
    localparam int MS  = 14;
    localparam int INV = 30;
    localparam int RG  = 60;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    health_shield_ctrl_if bus();
    health_shield_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: round is 0 idle / 1 fight / 2 knocked out.
    int m_h[2], m_s[2], m_inv[2], m_rg[2];
    int m_round, m_go, m_win;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int hit[2], dmg[2], blk[2], h_old[2];
        bit fighting;
        hit[0] = int'(bus.p1_hit);      hit[1] = int'(bus.p2_hit);
        dmg[0] = int'(bus.p1_dmg);      dmg[1] = int'(bus.p2_dmg);
        blk[0] = int'(bus.p1_blocking); blk[1] = int'(bus.p2_blocking);
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_h[p] = MH; m_s[p] = MS; m_inv[p] = 0; m_rg[p] = 0;
            end
            m_round = 0; m_go = 0; m_win = 0;
            return;
        end
        h_old[0] = m_h[0];
        h_old[1] = m_h[1];
        fighting = (m_round == 1) && (h_old[0] > 0) && (h_old[1] > 0);
        for (int p = 0; p < 2; p++) begin
            if (m_round == 0 || (m_round == 2 && bus.start)) begin
                m_h[p] = MH; m_s[p] = MS; m_inv[p] = 0; m_rg[p] = 0;
            end else if (fighting) begin
                if (hit[p] != 0 && dmg[p] != 0 && m_inv[p] == 0) begin
                    m_inv[p] = INV;
                    m_rg[p]  = 0;
                    if (blk[p] == 0) begin
                        m_h[p] = (m_h[p] > dmg[p]) ? m_h[p] - dmg[p] : 0;
                    end else if (m_s[p] >= dmg[p]) begin
                        m_s[p] = m_s[p] - dmg[p];
                    end else begin
                        int over;
                        over   = dmg[p] - m_s[p];
                        m_s[p] = 0;
                        m_h[p] = (m_h[p] > over) ? m_h[p] - over : 0;
                    end
                end else if (bus.frame_tick) begin
                    if (m_inv[p] > 0) m_inv[p]--;
                    if (blk[p] != 0) begin
                        m_rg[p] = 0;
                    end else begin
                        m_rg[p]++;
                        if (m_rg[p] >= RG) begin
                            m_rg[p] = 0;
                            if (m_s[p] < MS) m_s[p]++;
                        end
                    end
                end else if (blk[p] != 0) begin
                    m_rg[p] = 0;
                end
            end
        end
        if (m_round == 0) begin
            if (bus.start) m_round = 1;
        end else if (m_round == 1) begin
            if (h_old[0] == 0 || h_old[1] == 0) begin
                m_round = 2;
                m_go    = 1;
                if (h_old[0] == 0 && h_old[1] == 0) m_win = 3;
                else if (h_old[0] == 0)            m_win = 2;
                else                               m_win = 1;
            end
        end else if (bus.start) begin
            m_round = 1; m_go = 0; m_win = 0;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_val("p1_health", int'(bus.p1_health), m_h[0]);
        check_val("p2_health", int'(bus.p2_health), m_h[1]);
        check_val("p1_shield", int'(bus.p1_shield), m_s[0]);
        check_val("p2_shield", int'(bus.p2_shield), m_s[1]);
        check_val("game_over", int'(bus.game_over), m_go);
        check_val("winner",    int'(bus.winner),    m_win);
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        bus.p1_hit     = 1'b0;
        bus.p2_hit     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
        end
    endtask

    task automatic hit_p(input int p, input int d);
        if (p == 0) begin
            bus.p1_hit = 1'b1; bus.p1_dmg = 2'(d);
        end else begin
            bus.p2_hit = 1'b1; bus.p2_dmg = 2'(d);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.start = 1'b0;
        bus.p1_hit = 1'b0; bus.p2_hit = 1'b0;
        bus.p1_dmg = 2'd0; bus.p2_dmg = 2'd0;
        bus.p1_blocking = 1'b0; bus.p2_blocking = 1'b0;

        do_reset();
        check_val("rst_p1_health", int'(bus.p1_health), 14);
        check_val("rst_p2_shield", int'(bus.p2_shield), 14);
        check_val("rst_game_over", int'(bus.game_over), 0);
        check_val("rst_winner",    int'(bus.winner), 0);

        // First landed hit, unblocked.
        bus.start = 1'b1; step();
        hit_p(0, 3); step();
        check_val("hit1_p1_health", int'(bus.p1_health), 11);
        check_val("hit1_p1_shield", int'(bus.p1_shield), 14);

        // Immunity window: ignored at 5 ticks, accepted after 30.
        ticks(5);
        hit_p(0, 1); step();
        check_val("immune_p1_health", int'(bus.p1_health), 11);
        ticks(25);
        hit_p(0, 1); step();
        check_val("post_immune_p1_health", int'(bus.p1_health), 10);

        // Drain p2 shield to 2 with guarded hits, then overflow into health.
        bus.p2_blocking = 1'b1;
        for (int k = 0; k < 4; k++) begin
            hit_p(1, 3); step();
            ticks(INV);
        end
        check_val("guard_p2_shield", int'(bus.p2_shield), 2);
        hit_p(1, 3); step();
        check_val("break_p2_shield", int'(bus.p2_shield), 0);
        check_val("break_p2_health", int'(bus.p2_health), 13);
        bus.p2_blocking = 1'b0;

        // Shield regeneration from 10 and saturation at the maximum.
        bus.p1_blocking = 1'b1;
        hit_p(0, 3); step();
        ticks(INV);
        hit_p(0, 1); step();
        check_val("regen_start_p1_shield", int'(bus.p1_shield), 10);
        bus.p1_blocking = 1'b0;
        ticks(RG);
        check_val("regen_p1_shield", int'(bus.p1_shield), 11);
        ticks(3 * RG);
        check_val("regen_full_p1_shield", int'(bus.p1_shield), 14);
        ticks(RG);
        check_val("regen_sat_p1_shield", int'(bus.p1_shield), 14);

        // Double KO into a draw, then restart.
        do_reset();
        bus.start = 1'b1; step();
        for (int k = 0; k < 4; k++) begin
            hit_p(0, 3); hit_p(1, 3); step();
            ticks(INV);
        end
        hit_p(1, 1); step();
        ticks(INV);
        check_val("pre_ko_p1_health", int'(bus.p1_health), 2);
        check_val("pre_ko_p2_health", int'(bus.p2_health), 1);
        hit_p(0, 3); hit_p(1, 3); step();
        check_val("ko_p1_health", int'(bus.p1_health), 0);
        check_val("ko_p2_health", int'(bus.p2_health), 0);
        step();
        check_val("ko_game_over", int'(bus.game_over), 1);
        check_val("ko_winner",    int'(bus.winner), 3);
        hit_p(0, 2); step();
        check_val("ko_frozen_p1_health", int'(bus.p1_health), 0);
        bus.start = 1'b1; step();
        check_val("restart_p1_health", int'(bus.p1_health), 14);
        check_val("restart_p2_health", int'(bus.p2_health), 14);
        check_val("restart_winner",    int'(bus.winner), 0);
        check_val("restart_game_over", int'(bus.game_over), 0);
        hit_p(0, 1); step();
        check_val("restart_fight_p1_health", int'(bus.p1_health), 13);

        // Reset mid-fight with hits and start present.
        ticks(3);
        reset = 1'b1; bus.start = 1'b1; hit_p(0, 2); hit_p(1, 3); step();
        reset = 1'b0;
        check_val("midrst_p1_health", int'(bus.p1_health), 14);
        check_val("midrst_p2_health", int'(bus.p2_health), 14);
        check_val("midrst_p2_shield", int'(bus.p2_shield), 14);
        check_val("midrst_game_over", int'(bus.game_over), 0);
        check_val("midrst_winner",    int'(bus.winner), 0);

        // Randomized play against the model.
        for (int i = 0; i < 5000; i++) begin
            reset          = ($urandom_range(0, 799) == 0);
            bus.start      = ($urandom_range(0, 79) == 0);
            bus.frame_tick = ($urandom_range(0, 1) == 0);
            bus.p1_hit     = ($urandom_range(0, 3) == 0);
            bus.p2_hit     = ($urandom_range(0, 3) == 0);
            bus.p1_dmg     = 2'($urandom_range(0, 3));
            bus.p2_dmg     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus.p1_blocking = ~bus.p1_blocking;
            if ($urandom_range(0, 9) == 0) bus.p2_blocking = ~bus.p2_blocking;
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/health_shield_ctrl.md
HEALTH_SHIELD_CTRL -- requirements
Module: health_shield_ctrl

Interface
REQ-001 Parameter MAX_HEALTH, default 14, full health value per player; the largest value the bar display region holds.
REQ-002 Parameter MAX_SHIELD, default 14, full shield value per player.
REQ-003 Parameter INVULN_FRAMES, default 30, frame ticks of hit immunity after a landed hit.
REQ-004 Parameter REGEN_FRAMES, default 60, frame ticks per +1 shield regeneration.
REQ-005 clk  input  1  system clock; the single clock of the block.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 start  input  1  one-cycle pulse that starts or restarts a round.
REQ-009 p1_hit, p2_hit  input  1 each  one-cycle pulse: the named player was struck.
REQ-010 p1_dmg, p2_dmg  input  2 each  damage of the accompanying hit, 1..3; 0 means the hit is ignored.
REQ-011 p1_blocking, p2_blocking  input  1 each  level: the player is guarding.
REQ-012 p1_health, p2_health, p1_shield, p2_shield  output  4 each  registered values consumed by the bar renderer.
REQ-013 game_over  output  1  high in state KO.
REQ-014 winner  output  2  00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-015 The controller SHALL implement states IDLE, FIGHT and KO.
REQ-016 IDLE SHALL hold all vitals at maximum; start SHALL move it to FIGHT.
REQ-017 FIGHT SHALL apply hits; it SHALL move to KO on the cycle after any health reaches 0.
REQ-018 KO SHALL freeze the vitals; start SHALL reload the maxima, clear winner and move to FIGHT.
REQ-019 start in FIGHT SHALL be ignored; hits in IDLE or KO SHALL be ignored.
REQ-020 A hit to a player whose invulnerability counter is nonzero SHALL be ignored entirely.
REQ-021 Unblocked hit: health SHALL become max(health-dmg, 0); shield is unchanged.
REQ-022 Blocked hit with shield>=dmg: shield SHALL decrease by dmg; health is unchanged.
REQ-023 Blocked hit with shield<dmg: shield SHALL become 0; health SHALL become max(health-(dmg-shield), 0).
REQ-024 Every accepted hit SHALL load invulnerability=INVULN_FRAMES and clear that player's regen counter.
REQ-025 The invulnerability counter SHALL decrement by 1 per frame_tick, saturating at 0.
REQ-026 In FIGHT, while not blocking, the regen counter SHALL count frame_ticks.
REQ-027 When the regen counter reaches REGEN_FRAMES, shield SHALL increment (saturating at MAX_SHIELD) and the counter SHALL clear.
REQ-028 While blocking, the regen counter SHALL be held at 0.
REQ-029 A hit and a frame_tick in the same cycle: the hit SHALL take priority, with no regen and the invulnerability counter reloaded, not decremented.
REQ-030 Hits to both players in the same cycle SHALL both be applied.
REQ-031 If both healths reach 0 in the same cycle, winner SHALL be 11.
REQ-032 Otherwise the surviving player SHALL be declared winner.
REQ-033 All arithmetic SHALL use 5-bit intermediates so no underflow or overflow wraps.
REQ-034 Outputs SHALL change one cycle after the causing input (latency 1).

Reset
REQ-035 reset SHALL force state IDLE, all health and shield to maximum, all counters to 0, game_over=0 and winner=00, including mid-FIGHT and mid-KO.
REQ-036 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-037 MAX_HEALTH, MAX_SHIELD, the frame constants, the state encodings and the winner encodings SHALL live in a shared fighter constants package/include.
REQ-038 The per-player hit, shield, invulnerability and regen logic SHALL be a sub-module, player_vitals, instantiated twice.
REQ-039 The round FSM and winner logic SHALL stay in the top-level block.

Verification
REQ-040 reset, then start, then p1_hit dmg=3 unblocked -> next cycle p1_health=11, p1_shield=14.
REQ-041 p2_blocking=1, p2_shield=2, p2_hit dmg=3 -> p2_shield=0, p2_health=13.
REQ-042 A second p1_hit 5 frame_ticks after the first -> ignored; a hit after 30 frame_ticks -> applied.
REQ-043 p1_shield=10, no blocking for 60 frame_ticks -> p1_shield=11; at shield 14, 60 more ticks -> stays 14.
REQ-044 p1_health=2, p2_health=1, simultaneous hits dmg=3 -> both 0, game_over=1, winner=11; then start -> both 14, FIGHT, winner=00.
REQ-045 reset asserted mid-FIGHT with hit pulses present -> IDLE, all vitals 14, game_over=0, winner=00.
